// File: rtl/pipeline_pkg.sv
// Shared definitions for the data-path pipeline registers: EX/MEM bundle
// field widths and the encoding of the elastic stage-register states.
package pipeline_pkg;

  // EX/MEM bundle layout: {ctrls, aluout, writedata, writereg}
  localparam int CTRLS_W   = 3;
  localparam int WORD_W    = 32;
  localparam int REGADDR_W = 5;
  localparam int EXMEM_W   = CTRLS_W + WORD_W + WORD_W + REGADDR_W;

  // Stage-register occupancy states
  localparam logic [1:0] ST_EMPTY = 2'd0;  // nothing held
  localparam logic [1:0] ST_BUSY  = 2'd1;  // main slot held
  localparam logic [1:0] ST_FULL  = 2'd2;  // main and skid slots held

endpackage : pipeline_pkg

// File: rtl/sat_counter.sv
// Saturating up-counter: increments on i_inc and sticks at all-ones.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;
  logic             w_at_max;

  assign w_at_max = &r_count;
  assign o_count  = r_count;

  // Count enabled cycles until the counter is full, then hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_inc && !w_at_max) begin
      r_count <= r_count + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      r_count <= r_count;
    end
  end

endmodule : sat_counter

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline stage register: one packed bundle per beat, valid/ready
// handshake, 2-entry skid buffer so in_ready can be registered without losing
// throughput, synchronous flush and a saturating stall counter.
module pipe_stage_reg
  import pipeline_pkg::*;
#(
  parameter int DATA_W = EXMEM_W,
  parameter int CTRL_W = CTRLS_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic [1:0]        r_state;
  logic              r_main_valid;
  logic              r_skid_valid;
  logic [DATA_W-1:0] r_main_data;
  logic [DATA_W-1:0] r_skid_data;
  logic              r_in_ready;

  logic [1:0]        w_nxt_state;
  logic              w_nxt_main_valid;
  logic              w_nxt_skid_valid;
  logic              w_load_main_in;
  logic              w_load_main_skid;
  logic              w_load_skid_in;
  logic              w_accept;
  logic              w_deliver;
  logic              w_stall;
  logic [DATA_W-1:0] w_ctrl_mask;

  assign w_accept  = in_valid & r_in_ready;
  assign w_deliver = r_main_valid & out_ready;
  assign w_stall   = in_valid & ~r_in_ready;

  // Next-state and slot-load decisions; flush overrides all transitions.
  always_comb begin
    w_nxt_state      = r_state;
    w_nxt_main_valid = r_main_valid;
    w_nxt_skid_valid = r_skid_valid;
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid_in   = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_accept) begin
          w_load_main_in   = 1'b1;
          w_nxt_main_valid = 1'b1;
          w_nxt_state      = ST_BUSY;
        end else begin
          w_nxt_state      = ST_EMPTY;
        end
      end
      ST_BUSY: begin
        if (w_accept && w_deliver) begin
          w_load_main_in   = 1'b1;
          w_nxt_state      = ST_BUSY;
        end else if (w_accept) begin
          w_load_skid_in   = 1'b1;
          w_nxt_skid_valid = 1'b1;
          w_nxt_state      = ST_FULL;
        end else if (w_deliver) begin
          w_nxt_main_valid = 1'b0;
          w_nxt_state      = ST_EMPTY;
        end else begin
          w_nxt_state      = ST_BUSY;
        end
      end
      ST_FULL: begin
        if (w_deliver) begin
          w_load_main_skid = 1'b1;
          w_nxt_skid_valid = 1'b0;
          w_nxt_state      = ST_BUSY;
        end else begin
          w_nxt_state      = ST_FULL;
        end
      end
      default: begin
        w_nxt_state      = ST_EMPTY;
        w_nxt_main_valid = 1'b0;
        w_nxt_skid_valid = 1'b0;
      end
    endcase
    // A delivery in the flush cycle completes by itself since the downstream
    // already sampled out_valid; the incoming beat is simply not loaded.
    if (flush) begin
      w_nxt_state      = ST_EMPTY;
      w_nxt_main_valid = 1'b0;
      w_nxt_skid_valid = 1'b0;
      w_load_main_in   = 1'b0;
      w_load_main_skid = 1'b0;
      w_load_skid_in   = 1'b0;
    end else begin
      w_nxt_state      = w_nxt_state;
    end
  end

  // State, valid bits and the registered in_ready (derived from next skid valid).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_EMPTY;
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_in_ready   <= 1'b1;
    end else begin
      r_state      <= w_nxt_state;
      r_main_valid <= w_nxt_main_valid;
      r_skid_valid <= w_nxt_skid_valid;
      r_in_ready   <= ~w_nxt_skid_valid;
    end
  end

  // Main data slot: loads from upstream or from the skid slot only.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_main_data <= '0;
    end else if (w_load_main_in) begin
      r_main_data <= in_data;
    end else if (w_load_main_skid) begin
      r_main_data <= r_skid_data;
    end else begin
      r_main_data <= r_main_data;
    end
  end

  // Skid data slot: captures the beat that arrives while main is blocked.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_skid_data <= '0;
    end else if (w_load_skid_in) begin
      r_skid_data <= in_data;
    end else begin
      r_skid_data <= r_skid_data;
    end
  end

  // Mask selecting the top CTRL_W control bits of the bundle.
  always_comb begin
    w_ctrl_mask = '0;
    for (int i = 0; i < DATA_W; i++) begin
      if (i >= DATA_W - CTRL_W) begin
        w_ctrl_mask[i] = 1'b1;
      end else begin
        w_ctrl_mask[i] = 1'b0;
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_main_valid;
  // Stale data may sit in main after flush; zeroed control bits keep it inert.
  assign out_data  = r_main_valid ? r_main_data : (r_main_data & ~w_ctrl_mask);
  assign occupancy = {1'b0, r_main_valid} + {1'b0, r_skid_valid};

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_stall_cnt (
    .clk     (clk),
    .rst_n   (reset_n),
    .i_inc   (w_stall),
    .o_count (stall_cnt)
  );

endmodule : pipe_stage_reg

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: stimulus pushes expected beats into a
// queue, a negedge monitor pops and compares every delivered beat.
module tb_pipe_stage_reg;
  import pipeline_pkg::*;

  localparam int DW = EXMEM_W;

  logic          clk;
  logic          reset_n;
  logic          flush;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;
  logic [1:0]    occupancy;
  logic [15:0]   stall_cnt;

  logic          d2_in_ready;
  logic          d2_out_valid;
  logic [DW-1:0] d2_out_data;
  logic [1:0]    d2_occupancy;
  logic [2:0]    d2_stall_cnt;

  int checks   = 0;
  int failures = 0;
  logic [DW-1:0] exp_q[$];

  pipe_stage_reg dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .occupancy(occupancy), .stall_cnt(stall_cnt)
  );

  pipe_stage_reg #(.CNT_W(3)) dut_c3 (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(d2_in_ready),
    .out_valid(d2_out_valid), .out_data(d2_out_data), .out_ready(out_ready),
    .occupancy(d2_occupancy), .stall_cnt(d2_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] d, input bit expect_out);
    in_valid = 1'b1;
    in_data  = d;
    if (expect_out) exp_q.push_back(d);
    step();
  endtask

  // Monitor: every delivered beat must match the head of the scoreboard.
  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_beat: got %h expected none", out_data);
      end else begin
        chk("beat_data", out_data, exp_q.pop_front());
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] d0;
    logic [DW-1:0] ca, cb, cc;
    reset_n   = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    step();
    step();
    // Reset state
    chk("rst_in_ready",  {71'd0, in_ready},   {71'd0, 1'b1});
    chk("rst_out_valid", {71'd0, out_valid},  {71'd0, 1'b0});
    chk("rst_out_data",  out_data,            {DW{1'b0}});
    chk("rst_occupancy", {70'd0, occupancy},  {70'd0, 2'd0});
    chk("rst_stall",     {56'd0, stall_cnt},  {56'd0, 16'd0});
    reset_n = 1'b1;
    step();

    // Single beat, one-cycle latency
    d0 = {3'd5, 32'h0000_1234, 32'h0000_ABCD, 5'h0A};
    out_ready = 1'b1;
    send(d0, 1'b1);
    in_valid = 1'b0;
    chk("t1_out_valid", {71'd0, out_valid}, {71'd0, 1'b1});
    chk("t1_out_data",  out_data,           d0);
    chk("t1_occupancy", {70'd0, occupancy}, {70'd0, 2'd1});
    chk("t1_in_ready",  {71'd0, in_ready},  {71'd0, 1'b1});
    step();
    step();

    // Streaming 1..8 at full rate
    for (int i = 1; i <= 8; i++) begin
      send(DW'(i), 1'b1);
      chk("t2_no_gap", {71'd0, out_valid}, {71'd0, 1'b1});
    end
    in_valid = 1'b0;
    step();
    chk("t2_drained", {71'd0, out_valid}, {71'd0, 1'b0});
    chk("t2_stall",   {56'd0, stall_cnt}, {56'd0, 16'd0});

    // Backpressure into skid, stall counting, ordered release
    ca = {3'd1, 32'hAAAA_0001, 32'h1111_2222, 5'h01};
    cb = {3'd2, 32'hBBBB_0002, 32'h3333_4444, 5'h02};
    out_ready = 1'b0;
    send(ca, 1'b1);
    send(cb, 1'b1);
    chk("t3_occupancy", {70'd0, occupancy}, {70'd0, 2'd2});
    chk("t3_in_ready",  {71'd0, in_ready},  {71'd0, 1'b0});
    for (int i = 0; i < 5; i++) send({DW{1'b1}}, 1'b0);
    in_valid = 1'b0;
    chk("t3_stall5", {56'd0, stall_cnt}, {56'd0, 16'd5});
    out_ready = 1'b1;
    step();
    step();
    step();
    chk("t3_empty", {70'd0, occupancy}, {70'd0, 2'd0});

    // Flush from FULL discards held beats and the beat presented with flush
    out_ready = 1'b0;
    send({3'd3, 32'hCAFE_0003, 32'h0, 5'h03}, 1'b0);
    send({3'd4, 32'hCAFE_0004, 32'h0, 5'h04}, 1'b0);
    cc = {3'd7, 32'hDEAD_BEEF, 32'h0000_0C0C, 5'h1F};
    flush = 1'b1;
    send(cc, 1'b0);
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("t4_occupancy", {70'd0, occupancy},       {70'd0, 2'd0});
    chk("t4_out_valid", {71'd0, out_valid},       {71'd0, 1'b0});
    chk("t4_ctrl_zero", {69'd0, out_data[DW-1 -: 3]}, {69'd0, 3'd0});
    chk("t4_in_ready",  {71'd0, in_ready},        {71'd0, 1'b1});
    out_ready = 1'b1;
    step();
    step();

    // Asynchronous reset mid-stream
    send({3'd1, 32'h0000_0050, 32'h0, 5'h05}, 1'b0);
    in_data = {3'd1, 32'h0000_0051, 32'h0, 5'h06};
    #2;
    reset_n = 1'b0;
    #1;
    exp_q.delete();
    chk("t5_out_valid", {71'd0, out_valid}, {71'd0, 1'b0});
    chk("t5_out_data",  out_data,           {DW{1'b0}});
    chk("t5_occupancy", {70'd0, occupancy}, {70'd0, 2'd0});
    chk("t5_in_ready",  {71'd0, in_ready},  {71'd0, 1'b1});
    in_valid = 1'b0;
    #3;
    reset_n = 1'b1;
    step();
    d0 = {3'd6, 32'h1357_9BDF, 32'h2468_ACE0, 5'h11};
    send(d0, 1'b1);
    in_valid = 1'b0;
    chk("t5_post_valid", {71'd0, out_valid}, {71'd0, 1'b1});
    chk("t5_post_data",  out_data,           d0);
    step();
    step();

    // Saturation with a 3-bit counter
    out_ready = 1'b0;
    send(DW'(72'h21), 1'b1);
    send(DW'(72'h22), 1'b1);
    for (int i = 0; i < 7; i++) send({DW{1'b1}}, 1'b0);
    chk("t6_c3_at7",  {69'd0, d2_stall_cnt}, {69'd0, 3'd7});
    chk("t6_c16_at7", {56'd0, stall_cnt},    {56'd0, 16'd7});
    for (int i = 0; i < 3; i++) send({DW{1'b1}}, 1'b0);
    in_valid = 1'b0;
    chk("t6_c3_sat",   {69'd0, d2_stall_cnt}, {69'd0, 3'd7});
    chk("t6_c16_at10", {56'd0, stall_cnt},    {56'd0, 16'd10});
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();

    chk("scoreboard_empty", DW'(exp_q.size()), {DW{1'b0}});
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_pipe_stage_reg
